// File: rtl/nand_pkg.sv
// Shared types and constants for the NAND async command/address sequencer.
package nand_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      WE_LO = 3'd2,
      WE_HI = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      KIND_CMD  = 2'd0,
      KIND_ADDR = 2'd1,
      KIND_CMD2 = 2'd2
   } kind_t;

   localparam int unsigned NAND_MAX_ADDR_BYTES = 5;
   localparam int unsigned IDX_W               = 3;

   // Byte index 0 is CMD, 1..naddr are ADDR bytes, anything after is CMD2.
   function automatic kind_t byte_kind(input logic [IDX_W-1:0] idx,
                                       input logic [IDX_W-1:0] naddr);
      if (idx == IDX_W'(0))
         return KIND_CMD;
      else if (idx <= naddr)
         return KIND_ADDR;
      else
         return KIND_CMD2;
   endfunction

   // Address counts 6 and 7 behave as the maximum of 5.
   function automatic logic [IDX_W-1:0] clamp_naddr(input logic [IDX_W-1:0] n);
      if (n > IDX_W'(NAND_MAX_ADDR_BYTES))
         return IDX_W'(NAND_MAX_ADDR_BYTES);
      else
         return n;
   endfunction

endpackage

// File: rtl/nand_seq_timer.sv
// Loadable down-counter that stops at zero; expired while the count is zero.
module nand_seq_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_value;

   // Load on request, otherwise count down and hold at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_value <= '0;
      else if (i_load)
         r_value <= i_load_val;
      else if (r_value != '0)
         r_value <= r_value - CNT_W'(1);
   end

   assign o_expired = (r_value == '0);

endmodule

// File: rtl/nand_async_cmd_seq.sv
// NAND async-mode CMD / ADDR / CMD2 latch sequencer driving the PHY command path.
// Optional CMD2 phase: define NAND_CMD_SEQ_CMD2_EN.
module nand_async_cmd_seq
   import nand_pkg::*;
#(
   parameter int unsigned T_SETUP = 3,
   parameter int unsigned T_WP    = 2,
   parameter int unsigned T_WH    = 2,
   parameter int unsigned T_HOLD  = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk0,
   input  logic        rst0,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_chip,
   input  logic [7:0]  req_cmd,
   input  logic [2:0]  req_naddr,
   input  logic [39:0] req_addr,
   input  logic [7:0]  req_cmd2,
   input  logic        req_cmd2_vld,
   output logic        busy,
   output logic        done,
   output logic        ctrl_cle,
   output logic        ctrl_ale,
   output logic        ctrl_wrn,
   output logic [1:0]  ctrl_cen,
   output logic        ctrl_wen,
   output logic        ctrl_wen_sel,
   output logic        dq_cmd_sel,
   output logic        dq_cmd_oe_n,
   output logic [7:0]  wr_cmd
);

   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic               r_chip;
   logic [7:0]         r_cmd;
   logic [IDX_W-1:0]   r_naddr;
   logic [39:0]        r_addr;

   logic               w_accept, w_last, w_tmr_exp, w_tmr_load, w_cmd2_on;
   logic [CNT_W-1:0]   w_tmr_val;
   logic               w_chip_n;
   logic [7:0]         w_cmd_n, w_cmd2_n, w_byte;
   logic [IDX_W-1:0]   w_naddr_n;
   logic [39:0]        w_addr_n;
   kind_t              w_kind;

   logic               r_req_ready, r_busy, r_done, r_cle, r_ale, r_wen, r_wen_sel;
   logic               r_dq_cmd_sel, r_oe_n;
   logic [1:0]         r_cen;
   logic [7:0]         r_wr_cmd;
   logic               w_req_ready, w_busy, w_done, w_cle, w_ale, w_wen, w_oe_n, w_seq;
   logic [1:0]         w_cen;
   logic [7:0]         w_wr_cmd;

   assign w_accept = req_valid & r_req_ready;

   // Request fields as they will be once this cycle's acceptance (if any) lands.
   assign w_chip_n  = w_accept ? req_chip : r_chip;
   assign w_cmd_n   = w_accept ? req_cmd : r_cmd;
   assign w_naddr_n = w_accept ? clamp_naddr(req_naddr) : r_naddr;
   assign w_addr_n  = w_accept ? req_addr : r_addr;

`ifdef NAND_CMD_SEQ_CMD2_EN
   logic [7:0] r_cmd2;
   logic       r_cmd2_vld;

   // Capture the second command byte and its enable at acceptance.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_cmd2     <= 8'h00;
         r_cmd2_vld <= 1'b0;
      end else if (w_accept) begin
         r_cmd2     <= req_cmd2;
         r_cmd2_vld <= req_cmd2_vld;
      end
   end

   assign w_cmd2_n  = w_accept ? req_cmd2 : r_cmd2;
   assign w_cmd2_on = r_cmd2_vld;
`else
   logic w_unused_cmd2;
   assign w_unused_cmd2 = ^{req_cmd2, req_cmd2_vld};
   assign w_cmd2_n      = 8'h00;
   assign w_cmd2_on     = 1'b0;
`endif

   // Capture the request at acceptance; req_* are free to change afterwards.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_chip  <= 1'b0;
         r_cmd   <= 8'h00;
         r_naddr <= '0;
         r_addr  <= '0;
      end else if (w_accept) begin
         r_chip  <= req_chip;
         r_cmd   <= req_cmd;
         r_naddr <= clamp_naddr(req_naddr);
         r_addr  <= req_addr;
      end
   end

   // The byte just latched is the last one of the series.
   assign w_last = (r_idx == (r_naddr + IDX_W'(w_cmd2_on)));

   nand_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk0),
      .rst        (rst0),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_expired  (w_tmr_exp)
   );

   // State and byte index register.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next state, byte index advance and timer reload on each state entry.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         IDLE:  if (w_accept) begin
                   w_state_nxt = SETUP;
                   w_idx_nxt   = '0;
                end
         SETUP: if (w_tmr_exp) w_state_nxt = WE_LO;
         WE_LO: if (w_tmr_exp) w_state_nxt = WE_HI;
         WE_HI: if (w_tmr_exp) begin
                   if (w_last) begin
                      w_state_nxt = HOLD;
                   end else begin
                      w_state_nxt = SETUP;
                      w_idx_nxt   = r_idx + IDX_W'(1);
                   end
                end
         HOLD:  if (w_tmr_exp) w_state_nxt = DONE;
         DONE:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_tmr_load = (w_state_nxt != r_state);
      case (w_state_nxt)
         SETUP:   w_tmr_val = CNT_W'(T_SETUP - 1);
         WE_LO:   w_tmr_val = CNT_W'(T_WP - 1);
         WE_HI:   w_tmr_val = CNT_W'(T_WH - 1);
         HOLD:    w_tmr_val = CNT_W'(T_HOLD - 1);
         default: w_tmr_val = '0;
      endcase
   end

   // Select the byte for the upcoming index.
   always_comb begin
      w_kind = byte_kind(w_idx_nxt, w_naddr_n);
      w_byte = w_cmd_n;
      if (w_kind == KIND_CMD2) begin
         w_byte = w_cmd2_n;
      end else if (w_kind == KIND_ADDR) begin
         case (w_idx_nxt)
            3'd1:    w_byte = w_addr_n[7:0];
            3'd2:    w_byte = w_addr_n[15:8];
            3'd3:    w_byte = w_addr_n[23:16];
            3'd4:    w_byte = w_addr_n[31:24];
            3'd5:    w_byte = w_addr_n[39:32];
            default: w_byte = w_cmd_n;
         endcase
      end
   end

   // Output values decoded from the next state so registered outputs track the state.
   always_comb begin
      w_seq       = (w_state_nxt == SETUP) || (w_state_nxt == WE_LO) || (w_state_nxt == WE_HI);
      w_busy      = w_seq || (w_state_nxt == HOLD);
      w_req_ready = (w_state_nxt == IDLE);
      w_done      = (w_state_nxt == DONE);
      w_cen       = 2'b11;
      if (w_busy) w_cen[w_chip_n] = 1'b0;
      w_cle       = w_seq && (w_kind != KIND_ADDR);
      w_ale       = w_seq && (w_kind == KIND_ADDR);
      w_wen       = (w_state_nxt != WE_LO);
      w_oe_n      = !w_seq;
      w_wr_cmd    = w_seq ? w_byte : r_wr_cmd;
   end

   // Output registers.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         r_req_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cle        <= 1'b0;
         r_ale        <= 1'b0;
         r_cen        <= 2'b11;
         r_wen        <= 1'b1;
         r_wen_sel    <= 1'b0;
         r_dq_cmd_sel <= 1'b0;
         r_oe_n       <= 1'b1;
         r_wr_cmd     <= 8'h00;
      end else begin
         r_req_ready  <= w_req_ready;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_cle        <= w_cle;
         r_ale        <= w_ale;
         r_cen        <= w_cen;
         r_wen        <= w_wen;
         r_wen_sel    <= w_busy;
         r_dq_cmd_sel <= w_busy;
         r_oe_n       <= w_oe_n;
         r_wr_cmd     <= w_wr_cmd;
      end
   end

   assign req_ready    = r_req_ready;
   assign busy         = r_busy;
   assign done         = r_done;
   assign ctrl_cle     = r_cle;
   assign ctrl_ale     = r_ale;
   assign ctrl_wrn     = 1'b1;
   assign ctrl_cen     = r_cen;
   assign ctrl_wen     = r_wen;
   assign ctrl_wen_sel = r_wen_sel;
   assign dq_cmd_sel   = r_dq_cmd_sel;
   assign dq_cmd_oe_n  = r_oe_n;
   assign wr_cmd       = r_wr_cmd;

endmodule
